mfp_ahb_lite_master: RTL and testbench

- AHB-Lite bus initiator (single master) turning a simple valid/ready request port into pipelined single transfers.
- One transfer can be in the address phase while the previous one is in the data phase.
- Used by test/DMA-style engines to drive the slaves on the mfp AHB-Lite matrix, for example the GPIO and RAM slaves.

---
 rtl/mfp_ahb_lite_master.sv | 175 +++++++++++++++++
 tb/tb_mfp_ahb_lite_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_master.sv
// mfp_ahb_lite_master
//   AHB-Lite single-master initiator. Turns a valid/ready request port into
//   pipelined SINGLE transfers: one transfer may sit in the address phase (A)
//   while the previous one is in the data phase (D). Responses come back in
//   request order as a one-cycle rsp_valid pulse.
//
// Ports
//   HCLK, HRESET        clock, asynchronous active-high reset
//   req_*               request port (valid/ready handshake, byte address,
//                       HSIZE encoding, write data)
//   rsp_*               completion pulse, read data (0 for writes), error flag
//   H*                  AHB-Lite master interface
//
// Optional feature
//   MFP_AHB_MASTER_STATS_EN : adds stat_xfer_cnt / stat_err_cnt / stat_wait_cnt,
//   16-bit saturating counters of responses, error responses and data-phase
//   wait states.
module mfp_ahb_lite_master #(
   parameter int HADDR_WIDTH = 32,
   parameter int HDATA_WIDTH = 32
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [HADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]             req_size,
   input  logic [HDATA_WIDTH-1:0] req_wdata,
   output logic                   rsp_valid,
   output logic [HDATA_WIDTH-1:0] rsp_rdata,
   output logic                   rsp_err,
   output logic [HADDR_WIDTH-1:0] HADDR,
   output logic [1:0]             HTRANS,
   output logic                   HWRITE,
   output logic [2:0]             HSIZE,
   output logic [2:0]             HBURST,
   output logic [3:0]             HPROT,
   output logic                   HMASTLOCK,
   output logic [HDATA_WIDTH-1:0] HWDATA,
   input  logic [HDATA_WIDTH-1:0] HRDATA,
   input  logic                   HREADY,
   input  logic                   HRESP
`ifdef MFP_AHB_MASTER_STATS_EN
   ,
   output logic [15:0]            stat_xfer_cnt,
   output logic [15:0]            stat_err_cnt,
   output logic [15:0]            stat_wait_cnt
`endif
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   // address-phase register A (addr/write/size drive the bus directly)
   logic                   r_a_valid;
   logic [HADDR_WIDTH-1:0] r_a_addr;
   logic                   r_a_write;
   logic [2:0]             r_a_size;
   logic [HDATA_WIDTH-1:0] r_a_wdata;
   // data-phase register D
   logic                   r_d_valid;
   logic                   r_d_write;
   logic [HDATA_WIDTH-1:0] r_hwdata;
   // cancel flag: suppresses the pending address phase during a 2-cycle ERROR
   logic                   r_cancel;
   logic [1:0]             r_htrans;
   // response register R
   logic                   r_rsp_valid;
   logic [HDATA_WIDTH-1:0] r_rsp_rdata;
   logic                   r_rsp_err;

   logic                   w_accept;
   logic                   w_a_done;
   logic                   w_d_done;
   logic                   w_c_set;
   logic                   w_a_valid_nxt;
   logic                   w_c_nxt;
   logic [HADDR_WIDTH-1:0] w_addr_aligned;

   assign req_ready = !HRESET && !r_cancel && (!r_a_valid || HREADY);
   assign w_accept  = req_valid && req_ready;
   assign w_a_done  = r_a_valid && !r_cancel && HREADY;
   assign w_d_done  = r_d_valid && HREADY;
   // first ERROR cycle with a transfer queued behind it: pull HTRANS to IDLE
   assign w_c_set   = r_d_valid && HRESP && !HREADY && r_a_valid && !r_cancel;

   assign w_a_valid_nxt = w_accept ? 1'b1 : (w_a_done ? 1'b0 : r_a_valid);
   assign w_c_nxt       = w_c_set  ? 1'b1 : (w_d_done ? 1'b0 : r_cancel);

   always_comb begin
      w_addr_aligned = req_addr;
      if (req_size == 3'd1) w_addr_aligned[0]   = 1'b0;
      if (req_size == 3'd2) w_addr_aligned[1:0] = 2'b00;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_a_valid   <= 1'b0;
         r_a_addr    <= '0;
         r_a_write   <= 1'b0;
         r_a_size    <= 3'd0;
         r_a_wdata   <= '0;
         r_d_valid   <= 1'b0;
         r_d_write   <= 1'b0;
         r_hwdata    <= '0;
         r_cancel    <= 1'b0;
         r_htrans    <= TR_IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_a_valid <= w_a_valid_nxt;
         r_cancel  <= w_c_nxt;
         // HTRANS is registered from the next-state of A and C
         r_htrans  <= (w_a_valid_nxt && !w_c_nxt) ? TR_NONSEQ : TR_IDLE;
         if (w_accept) begin
            r_a_addr  <= w_addr_aligned;
            r_a_write <= req_write;
            r_a_size  <= req_size;
            r_a_wdata <= req_wdata;
         end
         if (w_a_done) begin
            r_d_valid <= 1'b1;
            r_d_write <= r_a_write;
            r_hwdata  <= r_a_wdata;
         end else if (w_d_done) begin
            r_d_valid <= 1'b0;
         end
         r_rsp_valid <= w_d_done;
         if (w_d_done) begin
            r_rsp_rdata <= r_d_write ? '0 : HRDATA;
            r_rsp_err   <= HRESP;
         end
      end
   end

   assign HADDR     = r_a_addr;
   assign HTRANS    = r_htrans;
   assign HWRITE    = r_a_write;
   assign HSIZE     = r_a_size;
   assign HWDATA    = r_hwdata;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

`ifdef MFP_AHB_MASTER_STATS_EN
   logic [15:0] r_xfer_cnt;
   logic [15:0] r_err_cnt;
   logic [15:0] r_wait_cnt;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_xfer_cnt <= 16'd0;
         r_err_cnt  <= 16'd0;
         r_wait_cnt <= 16'd0;
      end else begin
         if (r_rsp_valid && r_xfer_cnt != 16'hFFFF)
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
         if (r_rsp_valid && r_rsp_err && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
         if (r_d_valid && !HREADY && r_wait_cnt != 16'hFFFF)
            r_wait_cnt <= r_wait_cnt + 16'd1;
      end
   end

   assign stat_xfer_cnt = r_xfer_cnt;
   assign stat_err_cnt  = r_err_cnt;
   assign stat_wait_cnt = r_wait_cnt;
`endif

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master. A tiny slave model latches the
// address of each accepted NONSEQ and returns HRDATA = that address + 1 in the
// data phase; HREADY/HRESP are driven per step.
module tb_mfp_ahb_lite_master;
   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
`ifdef MFP_AHB_MASTER_STATS_EN
   logic [15:0] stat_xfer_cnt, stat_err_cnt, stat_wait_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] dph_addr = 32'd0;

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) if (HTRANS == 2'b10 && HREADY) dph_addr <= HADDR;
   assign HRDATA = dph_addr + 32'd1;

   mfp_ahb_lite_master #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
`ifdef MFP_AHB_MASTER_STATS_EN
      , .stat_xfer_cnt(stat_xfer_cnt), .stat_err_cnt(stat_err_cnt),
      .stat_wait_cnt(stat_wait_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge HCLK);
   endtask

   initial begin
      HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_size = 3'd0; req_wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
      tick(); tick();
      // reset state
      chk("rst_ready", req_ready, 0);
      chk("rst_htrans", HTRANS, 0);
      chk("rst_rspv", rsp_valid, 0);
      chk("rst_haddr", HADDR, 0);
      chk("rst_hwdata", HWDATA, 0);
      chk("rst_hsize", HSIZE, 0);
      chk("rst_hwrite", HWRITE, 0);
      chk("rst_rsperr", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("hburst", HBURST, 0);
      chk("hprot", HPROT, 4'b0011);
      chk("hmastlock", HMASTLOCK, 0);
      HRESET = 1'b0; #1;
      chk("rdy_after_rst", req_ready, 1);

      // single write, zero wait states
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0004;
      req_size = 3'd2; req_wdata = 32'hDEADBEEF;
      tick();
      chk("wr_c1_htrans", HTRANS, 2);
      chk("wr_c1_hwrite", HWRITE, 1);
      chk("wr_c1_haddr", HADDR, 32'h1000_0004);
      chk("wr_c1_hsize", HSIZE, 2);
      chk("wr_c1_rspv", rsp_valid, 0);
      req_valid = 1'b0; req_write = 1'b0;
      tick();
      chk("wr_c2_htrans", HTRANS, 0);
      chk("wr_c2_hwdata", HWDATA, 32'hDEADBEEF);
      chk("wr_c2_rspv", rsp_valid, 0);
      tick();
      chk("wr_c3_rspv", rsp_valid, 1);
      chk("wr_c3_err", rsp_err, 0);
      chk("wr_c3_rdata", rsp_rdata, 0);
      tick();
      chk("wr_c4_rspv", rsp_valid, 0);

      // four back-to-back reads
      req_valid = 1'b1; req_addr = 32'h100; req_size = 3'd2;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 4) begin
            chk("b2b_htrans", HTRANS, 2);
            chk("b2b_haddr", HADDR, 32'h100 + 32'(4 * i));
         end else begin
            chk("b2b_idle", HTRANS, 0);
         end
         if (i >= 2) begin
            chk("b2b_rspv", rsp_valid, 1);
            chk("b2b_rdata", rsp_rdata, 32'h101 + 32'(4 * (i - 2)));
         end else begin
            chk("b2b_norsp", rsp_valid, 0);
         end
         if (i < 3) req_addr = 32'h100 + 32'(4 * (i + 1));
         else req_valid = 1'b0;
      end
      tick();
      chk("b2b_end_rspv", rsp_valid, 0);

      // read with 3 wait states, next read queued behind it
      req_valid = 1'b1; req_addr = 32'h200;
      tick();
      chk("ws_c1_haddr", HADDR, 32'h200);
      req_addr = 32'h204;
      tick();
      chk("ws_c2_haddr", HADDR, 32'h204);
      chk("ws_c2_htrans", HTRANS, 2);
      req_valid = 1'b0; HREADY = 1'b0; #1;
      chk("ws_c2_ready", req_ready, 0);
      tick();
      chk("ws_c3_haddr", HADDR, 32'h204);
      chk("ws_c3_rspv", rsp_valid, 0);
      tick();
      chk("ws_c4_haddr", HADDR, 32'h204);
      chk("ws_c4_rspv", rsp_valid, 0);
      tick();
      chk("ws_c5_haddr", HADDR, 32'h204);
      chk("ws_c5_htrans", HTRANS, 2);
      chk("ws_c5_rspv", rsp_valid, 0);
      HREADY = 1'b1;
      tick();
      chk("ws_c6_rspv", rsp_valid, 1);
      chk("ws_c6_rdata", rsp_rdata, 32'h201);
      chk("ws_c6_htrans", HTRANS, 0);
      tick();
      chk("ws_c7_rspv", rsp_valid, 1);
      chk("ws_c7_rdata", rsp_rdata, 32'h205);
      tick();
      chk("ws_c8_rspv", rsp_valid, 0);
`ifdef MFP_AHB_MASTER_STATS_EN
      chk("stat_wait_3", stat_wait_cnt, 3);
      chk("stat_xfer_7", stat_xfer_cnt, 7);
      chk("stat_err_0", stat_err_cnt, 0);
`endif

      // write gets ERROR while a read is queued in the address phase
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_wdata = 32'h55;
      tick();
      chk("er_c1_haddr", HADDR, 32'h300);
      chk("er_c1_hwrite", HWRITE, 1);
      req_write = 1'b0; req_addr = 32'h308;
      tick();
      chk("er_c2_haddr", HADDR, 32'h308);
      chk("er_c2_htrans", HTRANS, 2);
      chk("er_c2_hwdata", HWDATA, 32'h55);
      req_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
      tick();
      chk("er_c3_idle", HTRANS, 0);
      chk("er_c3_haddr", HADDR, 32'h308);
      chk("er_c3_rspv", rsp_valid, 0);
      HREADY = 1'b1; #1;
      chk("er_c3_ready", req_ready, 0);
      tick();
      chk("er_c4_rspv", rsp_valid, 1);
      chk("er_c4_err", rsp_err, 1);
      chk("er_c4_rdata", rsp_rdata, 0);
      chk("er_c4_reissue", HTRANS, 2);
      chk("er_c4_haddr", HADDR, 32'h308);
      HRESP = 1'b0;
      tick();
      chk("er_c5_rspv", rsp_valid, 0);
      chk("er_c5_idle", HTRANS, 0);
      tick();
      chk("er_c6_rspv", rsp_valid, 1);
      chk("er_c6_err", rsp_err, 0);
      chk("er_c6_rdata", rsp_rdata, 32'h309);
      tick();
`ifdef MFP_AHB_MASTER_STATS_EN
      chk("stat_xfer_9", stat_xfer_cnt, 9);
      chk("stat_err_1", stat_err_cnt, 1);
      chk("stat_wait_4", stat_wait_cnt, 4);
`endif

      // half-word to an odd address is aligned down
      req_valid = 1'b1; req_addr = 32'h3; req_size = 3'd1;
      tick();
      chk("hw_haddr", HADDR, 32'h2);
      chk("hw_hsize", HSIZE, 1);
      chk("hw_htrans", HTRANS, 2);
      req_valid = 1'b0;
      tick(); tick();
      chk("hw_rspv", rsp_valid, 1);
      chk("hw_rdata", rsp_rdata, 32'h3);

      // reset pulsed during a data phase with another transfer queued
      req_valid = 1'b1; req_addr = 32'h400; req_size = 3'd2;
      tick();
      chk("rs_c1_htrans", HTRANS, 2);
      req_addr = 32'h404;
      tick();
      HRESET = 1'b1; #1;
      chk("rs_idle", HTRANS, 0);
      chk("rs_ready", req_ready, 0);
      chk("rs_haddr", HADDR, 0);
      chk("rs_rspv", rsp_valid, 0);
      req_valid = 1'b0;
      tick();
      chk("rs_hold_rspv", rsp_valid, 0);
      chk("rs_hold_ready", req_ready, 0);
      HRESET = 1'b0; #1;
      chk("rs_rel_ready", req_ready, 1);
      tick();
      chk("rs_p1_rspv", rsp_valid, 0);
      chk("rs_p1_htrans", HTRANS, 0);
      tick();
      chk("rs_p2_rspv", rsp_valid, 0);
`ifdef MFP_AHB_MASTER_STATS_EN
      chk("stat_rst_xfer", stat_xfer_cnt, 0);
      chk("stat_rst_wait", stat_wait_cnt, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
